fwd_scoreboard: RTL

- Parametrised operand bypass and hazard unit for the multi-issue integer pipeline. Sits in decode/issue.
- Each read port selects data from the youngest matching in-flight producer, from a completing long-latency unit (mult/div/HI-LO class), or from the register file.
- Raises a stall when the selected producer's data is not yet available.
- Tracks outstanding long-latency destinations in a registered busy scoreboard.

---
 rtl/fwd_pkg.sv | 34 +++
 rtl/fwd_port_sel.sv | 62 ++++++
 rtl/fwd_scoreboard.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// fwd_pkg: shared constants and types for the operand bypass / hazard unit.
package fwd_pkg;

    localparam int FWD_DATA_W  = 32;
    localparam int FWD_REG_NUM = 32;
    localparam int FWD_ADDR_W  = $clog2(FWD_REG_NUM);
    localparam int FWD_LANES   = 2;
    localparam int FWD_STAGES  = 2;
    localparam int FWD_RPORTS  = 4;
    localparam int FWD_LP_MAX  = 2;

    // Where a read port's operand came from this cycle
    typedef enum logic [2:0] {
        SRC_ZERO,
        SRC_BYP,
        SRC_LP,
        SRC_RF,
        SRC_STALL
    } fwd_src_e;

    // One in-flight producer as seen by the bypass network (default widths)
    typedef struct packed {
        logic                  wen;
        logic [FWD_ADDR_W-1:0] waddr;
        logic [FWD_DATA_W-1:0] wdata;
        logic                  ready;
    } byp_entry_t;

    // Operand was served by a forwarding path rather than the register file
    function automatic logic src_is_hit(input fwd_src_e s);
        return (s == SRC_BYP) || (s == SRC_LP);
    endfunction

endpackage

// File: rtl/fwd_port_sel.sv
// fwd_port_sel: combinational operand select for a single read port.
// Priority: r0, youngest matching bypass entry, same-cycle long-latency
// completion, busy scoreboard hazard, register file.
module fwd_port_sel
    import fwd_pkg::*;
#(
    parameter int DATA_W = FWD_DATA_W,
    parameter int ADDR_W = FWD_ADDR_W,
    parameter int LANES  = FWD_LANES,
    parameter int STAGES = FWD_STAGES
) (
    input  logic [ADDR_W-1:0]                      rd_addr,
    input  logic [DATA_W-1:0]                      rd_rfdata,
    input  logic [STAGES*LANES-1:0]                byp_wen,
    input  logic [STAGES*LANES-1:0][ADDR_W-1:0]    byp_waddr,
    input  logic [STAGES*LANES-1:0][DATA_W-1:0]    byp_wdata,
    input  logic [STAGES*LANES-1:0]                byp_ready,
    input  logic                                   lp_done_valid,
    input  logic [ADDR_W-1:0]                      lp_done_addr,
    input  logic [DATA_W-1:0]                      lp_done_data,
    input  logic                                   busy,
    output logic [DATA_W-1:0]                      rd_data,
    output fwd_src_e                               src
);

    logic found;

    // First match wins: stage 0 first, highest lane first within a stage.
    // A matching producer that is not ready blocks all older sources.
    always_comb begin
        rd_data = rd_rfdata;
        src     = SRC_RF;
        found   = 1'b0;
        if (rd_addr == '0) begin
            rd_data = '0;
            src     = SRC_ZERO;
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                for (int l = LANES - 1; l >= 0; l--) begin
                    if (!found && byp_wen[s*LANES+l] && (byp_waddr[s*LANES+l] == rd_addr)) begin
                        found = 1'b1;
                        if (byp_ready[s*LANES+l]) begin
                            rd_data = byp_wdata[s*LANES+l];
                            src     = SRC_BYP;
                        end else begin
                            src     = SRC_STALL;
                        end
                    end
                end
            end
            if (!found) begin
                if (lp_done_valid && (lp_done_addr == rd_addr)) begin
                    rd_data = lp_done_data;
                    src     = SRC_LP;
                end else if (busy) begin
                    src     = SRC_STALL;
                end
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: operand bypass and hazard unit for the multi-issue pipe.
// Holds the long-latency busy scoreboard and outstanding count; operand
// selection is purely combinational per port.
// Optional: define FWD_PERF_EN to add forwarding-hit and stall-cycle counters.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int DATA_W  = FWD_DATA_W,
    parameter int REG_NUM = FWD_REG_NUM,
    parameter int ADDR_W  = $clog2(REG_NUM),
    parameter int LANES   = FWD_LANES,
    parameter int STAGES  = FWD_STAGES,
    parameter int RPORTS  = FWD_RPORTS,
    parameter int LP_MAX  = FWD_LP_MAX
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [STAGES*LANES-1:0]              byp_wen,
    input  logic [STAGES*LANES-1:0][ADDR_W-1:0]  byp_waddr,
    input  logic [STAGES*LANES-1:0][DATA_W-1:0]  byp_wdata,
    input  logic [STAGES*LANES-1:0]              byp_ready,
    input  logic [RPORTS-1:0][ADDR_W-1:0]        rd_addr,
    input  logic [RPORTS-1:0][DATA_W-1:0]        rd_rfdata,
    output logic [RPORTS-1:0][DATA_W-1:0]        rd_data,
    output logic [RPORTS-1:0]                    rd_stall,
    output logic                                 stall,
    input  logic                                 lp_alloc_valid,
    input  logic [ADDR_W-1:0]                    lp_alloc_addr,
    output logic                                 lp_alloc_ready,
    input  logic                                 lp_done_valid,
    input  logic [ADDR_W-1:0]                    lp_done_addr,
    input  logic [DATA_W-1:0]                    lp_done_data,
    output logic [REG_NUM-1:0]                   lp_busy,
`ifdef FWD_PERF_EN
    output logic [31:0]                          perf_fwd_hits,
    output logic [31:0]                          perf_stall_cycles,
`endif
    input  logic                                 flush
);

    localparam int              CNT_W    = $clog2(LP_MAX + 1);
    localparam logic [CNT_W-1:0] LP_MAX_C = CNT_W'(LP_MAX);

    logic [REG_NUM-1:0] busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               alloc_fire, done_fire;
    fwd_src_e           src [RPORTS];

    assign lp_busy        = busy_q;
    assign lp_alloc_ready = (cnt_q < LP_MAX_C);
    assign stall          = |rd_stall;

    for (genvar p = 0; p < RPORTS; p++) begin : g_port
        fwd_port_sel #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .LANES  (LANES),
            .STAGES (STAGES)
        ) u_sel (
            .rd_addr       (rd_addr[p]),
            .rd_rfdata     (rd_rfdata[p]),
            .byp_wen       (byp_wen),
            .byp_waddr     (byp_waddr),
            .byp_wdata     (byp_wdata),
            .byp_ready     (byp_ready),
            .lp_done_valid (lp_done_valid),
            .lp_done_addr  (lp_done_addr),
            .lp_done_data  (lp_done_data),
            .busy          (busy_q[rd_addr[p]]),
            .rd_data       (rd_data[p]),
            .src           (src[p])
        );
        assign rd_stall[p] = (src[p] == SRC_STALL);
    end

    // Scoreboard next state: done clears before alloc sets, so a same-address
    // alloc+done leaves the register busy. Flush discards both.
    always_comb begin
        alloc_fire = lp_alloc_valid && lp_alloc_ready;
        done_fire  = lp_done_valid && (cnt_q != '0);
        busy_d     = busy_q;
        cnt_d      = cnt_q;
        if (done_fire) busy_d[lp_done_addr] = 1'b0;
        if (alloc_fire && (lp_alloc_addr != '0)) busy_d[lp_alloc_addr] = 1'b1;
        if (alloc_fire && !done_fire) cnt_d = cnt_q + CNT_W'(1);
        if (!alloc_fire && done_fire) cnt_d = cnt_q - CNT_W'(1);
        if (flush) begin
            busy_d = '0;
            cnt_d  = '0;
        end
    end

    // Scoreboard registers
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

`ifdef FWD_PERF_EN
    localparam int HIT_W = $clog2(RPORTS + 1);

    logic [HIT_W-1:0] n_hits;
    logic [32:0]      hits_sum;
    logic [31:0]      hits_q, hits_d, stl_q, stl_d;

    assign perf_fwd_hits     = hits_q;
    assign perf_stall_cycles = stl_q;

    // Saturating counters: per-cycle forwarding hits and stalled cycles
    always_comb begin
        n_hits = '0;
        for (int p = 0; p < RPORTS; p++) begin
            if (src_is_hit(src[p])) n_hits = n_hits + HIT_W'(1);
        end
        hits_sum = {1'b0, hits_q} + 33'(n_hits);
        hits_d   = hits_sum[32] ? '1 : hits_sum[31:0];
        stl_d    = (stall && (stl_q != '1)) ? stl_q + 32'd1 : stl_q;
    end

    // Performance counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            hits_q <= '0;
            stl_q  <= '0;
        end else begin
            hits_q <= hits_d;
            stl_q  <= stl_d;
        end
    end
`endif

endmodule
